sq_ref_gen: RTL and testbench
=============================

Name: sq_ref_gen

Overview:
Square-wave reference generator that drives the `ref` input of the square-multiplier demodulators in the lock-in chain. It produces the in-phase reference, a quadrature reference (90°), and a phase-shifted reference for demodulation. It also produces a signed ±amp modulation output for the DAC path and a period-sync pulse. Period and phase are set by registers, with glitch-free updates at period boundaries.

Parameters:
N, 32, width of half-period and phase registers (counts of clk).
R, 14, width of signed amplitude and modulation output.

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous, active-high.
en  in  1  count enable; low freezes the counter.
hp_in  in  N  half-period in clk cycles; full period P = 2*hp.
phase_in  in  N  delay of phs_out relative to ref_out, in clk cycles.
amp  in  R  signed modulation amplitude.
ref_out  out  1  in-phase square reference.
quad_out  out  1  quadrature reference, delayed floor(hp/2) cycles from ref_out.
phs_out  out  1  reference delayed by phase cycles.
mod_out  out  R  signed: +amp when ref_out=1, -amp (saturated) when ref_out=0.
sync  out  1  one-cycle pulse coincident with each rising edge of ref_out.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Shadow registers hp_s and ph_s:
  - loaded from hp_in and phase_in during rst;
  - loaded on every wrap (en=1 and cnt==P_s-1);
  - loaded every cycle while hp_s==0.
  - No other loads; mid-period input changes are ignored until the next wrap.
- Period and counter:
  - P_s = 2*hp_s, computed in N+1 bits with no overflow.
  - cnt is N+1 bits. Reset value 0.
  - If en=1 and hp_s!=0: cnt <= (cnt==P_s-1) ? 0 : cnt+1.
  - Otherwise cnt holds.
- Combinational phase positions, each in 0..P_s-1:
  - a = cnt.
  - q = (cnt + P_s - floor(hp_s/2)) mod P_s.
  - p = (cnt + P_s - ph_eff) mod P_s, where ph_eff = (ph_s < P_s) ? ph_s : 0.
- Registered outputs, one cycle of latency after cnt:
  - ref_out <= (a < hp_s).
  - quad_out <= (q < hp_s).
  - phs_out <= (p < hp_s).
  - sync <= en & (cnt==0) & (hp_s!=0).
  - mod_out <= ref_next ? amp : neg(amp).
- neg(amp) = -amp, except amp = -2^(R-1) gives 2^(R-1)-1.
- amp is sampled live every cycle, not shadowed.
- hp_s==0: ref_out, quad_out, phs_out, sync and mod_out all register 0.
- en=0: counter frozen; ref_out, quad_out, phs_out and mod_out keep reflecting the frozen cnt (mod_out still tracks amp); sync=0.
- Reset values: ref_out=0, quad_out=0, phs_out=0, mod_out=0, sync=0, cnt=0.
- After rst deasserts with en=1 and hp_s!=0: first edge gives ref_out=1 and sync=1, then cnt advances.
- Reset mid-period: returns cnt to 0 immediately and restarts the period from phase 0.
- Arithmetic widths: all modular arithmetic in N+1 bits. The mod is a single conditional subtract; both operands are already < 2*P_s.

Test Plan:
- Basic timing. rst for 2 cycles, hp_in=4, phase_in=0, amp=1000, en=1.
  -> ref_out = 1,1,1,1,0,0,0,0 repeating from the first post-reset edge.
  -> sync high on cycles 1, 9, 17.
  -> mod_out = +1000 / -1000 aligned with ref_out.
- Quadrature and phase. hp_in=4, phase_in=3.
  -> quad_out equals ref_out delayed 2 cycles.
  -> phs_out equals ref_out delayed 3 cycles.
  -> phase_in=9 (≥P=8) gives phs_out identical to ref_out.
- Glitch-free update. Running with hp=4, set hp_in=2 at cnt=2.
  -> the current 8-cycle period completes unchanged.
  -> next periods are 1,1,0,0.
  -> sync spacing changes from 8 to 4 only after the wrap.
- Saturation. amp=-8192 (R=14).
  -> mod_out = -8192 when ref_out=1 and +8191 when ref_out=0.
  -> amp=0 gives mod_out=0 throughout.
- Zero period. hp_in=0.
  -> all outputs 0, no sync.
  -> setting hp_in=3 gives first sync within 2 cycles, then a 6-cycle period.
- Enable and reset. Drop en for 5 cycles mid-high-phase.
  -> outputs hold, sync stays 0.
  -> resuming en continues the count with no lost state.
  -> asserting rst mid-period gives all outputs 0 next edge, then a restart with ref_out=1 and sync=1.

Source files
------------

// File: rtl/sq_ref_gen.sv
// ============================================================================
// Module      : sq_ref_gen
// Description : Square-wave reference generator for the lock-in demodulators.
//               Produces in-phase, quadrature and phase-shifted references, a
//               signed +/-amp modulation output and a period-sync pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_ref_gen #(
  parameter int N = 32,
  parameter int R = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N-1:0]        hp_in,
  input  logic [N-1:0]        phase_in,
  input  logic signed [R-1:0] amp,
  output logic                ref_out,
  output logic                quad_out,
  output logic                phs_out,
  output logic signed [R-1:0] mod_out,
  output logic                sync
);

  localparam logic [N:0]        c_one     = (N+1)'(1);
  localparam logic signed [R-1:0] c_amp_min = {1'b1, {(R-1){1'b0}}};
  localparam logic signed [R-1:0] c_amp_max = {1'b0, {(R-1){1'b1}}};

  logic [N-1:0]        r_hp_s;
  logic [N-1:0]        r_ph_s;
  logic [N:0]          r_cnt;

  logic [N:0]          w_per;
  logic [N:0]          w_hp_ext;
  logic [N:0]          w_h2;
  logic [N:0]          w_ph_ext;
  logic [N:0]          w_ph_eff;
  logic [N:0]          w_q;
  logic [N:0]          w_p;
  logic                w_hp_zero;
  logic                w_wrap;
  logic                w_ref_next;
  logic signed [R-1:0] w_neg;

  assign w_per     = {r_hp_s, 1'b0};
  assign w_hp_ext  = {1'b0, r_hp_s};
  assign w_h2      = {2'b00, r_hp_s[N-1:1]};
  assign w_ph_ext  = {1'b0, r_ph_s};
  assign w_ph_eff  = (w_ph_ext < w_per) ? w_ph_ext : '0;
  assign w_hp_zero = (r_hp_s == '0);
  assign w_wrap    = en && !w_hp_zero && (r_cnt == (w_per - c_one));

  // Modular subtraction split on the borrow so no intermediate exceeds N+1 bits
  assign w_q = (r_cnt >= w_h2)     ? (r_cnt - w_h2)     : (r_cnt + (w_per - w_h2));
  assign w_p = (r_cnt >= w_ph_eff) ? (r_cnt - w_ph_eff) : (r_cnt + (w_per - w_ph_eff));

  assign w_ref_next = (r_cnt < w_hp_ext);
  assign w_neg      = (amp == c_amp_min) ? c_amp_max : -amp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hp_s   <= hp_in;
      r_ph_s   <= phase_in;
      r_cnt    <= '0;
      ref_out  <= 1'b0;
      quad_out <= 1'b0;
      phs_out  <= 1'b0;
      sync     <= 1'b0;
      mod_out  <= '0;
    end else begin
      // Shadows only move at a period boundary, or freely while idle at hp=0
      if (w_wrap || w_hp_zero) begin
        r_hp_s <= hp_in;
        r_ph_s <= phase_in;
      end
      if (en && !w_hp_zero) begin
        r_cnt <= w_wrap ? '0 : (r_cnt + c_one);
      end
      ref_out  <= w_ref_next;
      quad_out <= (w_q < w_hp_ext);
      phs_out  <= (w_p < w_hp_ext);
      sync     <= en && (r_cnt == '0) && !w_hp_zero;
      mod_out  <= w_hp_zero ? '0 : (w_ref_next ? amp : w_neg);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sq_ref_gen.sv
// ============================================================================
// Module      : tb_sq_ref_gen
// Description : Directed self-checking bench for sq_ref_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sq_ref_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [31:0]        hp_in;
  logic [31:0]        phase_in;
  logic signed [13:0] amp;
  logic               ref_out;
  logic               quad_out;
  logic               phs_out;
  logic signed [13:0] mod_out;
  logic               sync;

  int n_vec = 0;
  int n_err = 0;

  sq_ref_gen #(.N(32), .R(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .hp_in    (hp_in),
    .phase_in (phase_in),
    .amp      (amp),
    .ref_out  (ref_out),
    .quad_out (quad_out),
    .phs_out  (phs_out),
    .mod_out  (mod_out),
    .sync     (sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge per character; patterns are the expected output after each edge
  task automatic run_seq(input string tag, input string r, input string q,
                         input string p, input string s,
                         input longint plus, input longint minus);
    for (int k = 0; k < r.len(); k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].ref", tag, k),  longint'(ref_out),  longint'(r[k] == "1"));
      chk($sformatf("%s[%0d].quad", tag, k), longint'(quad_out), longint'(q[k] == "1"));
      chk($sformatf("%s[%0d].phs", tag, k),  longint'(phs_out),  longint'(p[k] == "1"));
      chk($sformatf("%s[%0d].sync", tag, k), longint'(sync),     longint'(s[k] == "1"));
      chk($sformatf("%s[%0d].mod", tag, k),  longint'(mod_out),  (r[k] == "1") ? plus : minus);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; hp_in = 32'd4; phase_in = 32'd0; amp = 14'sd1000;

    // Reset state, then basic timing with hp=4
    run_seq("rst", "00", "00", "00", "00", 0, 0);
    rst = 1'b0;
    run_seq("basic", "11110000111100001", "00111100001111000",
            "11110000111100001", "10000000100000001", 1000, -1000);

    // Quadrature and phase = 3
    rst = 1'b1; phase_in = 32'd3;
    run_seq("rst2", "0", "0", "0", "0", 0, 0);
    rst = 1'b0;
    run_seq("phase3", "1111000011110000", "0011110000111100",
            "0001111000011110", "1000000010000000", 1000, -1000);

    // Phase beyond the period collapses to zero delay
    rst = 1'b1; phase_in = 32'd9;
    run_seq("rst3", "0", "0", "0", "0", 0, 0);
    rst = 1'b0;
    run_seq("phase9", "11110000", "00111100", "11110000", "10000000", 1000, -1000);

    // Glitch-free half-period change requested at cnt=2
    rst = 1'b1; phase_in = 32'd0;
    run_seq("rst4", "0", "0", "0", "0", 0, 0);
    rst = 1'b0;
    run_seq("upd_a", "11", "00", "11", "10", 1000, -1000);
    hp_in = 32'd2;
    run_seq("upd_b", "11000011001100", "11110001100110",
            "11000011001100", "00000010001000", 1000, -1000);

    // Saturated negation of the most negative amplitude, then zero amplitude
    amp = -14'sd8192;
    run_seq("sat", "11001100", "01100110", "11001100", "10001000", -8192, 8191);
    amp = 14'sd0;
    run_seq("amp0", "1100", "0110", "1100", "1000", 0, 0);

    // Zero half-period: everything idles at 0
    rst = 1'b1; hp_in = 32'd0; amp = 14'sd1000;
    run_seq("rst5", "0", "0", "0", "0", 0, 0);
    rst = 1'b0;
    run_seq("hp0", "000000", "000000", "000000", "000000", 0, 0);
    hp_in = 32'd3;
    run_seq("hp3_load", "0", "0", "0", "0", 0, 0);
    run_seq("hp3", "1110001", "0111000", "1110001", "1000001", 1000, -1000);

    // Freeze mid high phase; amp still tracked live
    run_seq("pre_frz", "1", "1", "1", "0", 1000, -1000);
    en = 1'b0; amp = -14'sd500;
    run_seq("frz", "11111", "11111", "11111", "00000", -500, 500);
    en = 1'b1;
    run_seq("resume", "10001", "11000", "10001", "00001", -500, 500);

    // Mid-period reset restarts from phase 0
    rst = 1'b1;
    run_seq("rst6", "0", "0", "0", "0", 0, 0);
    rst = 1'b0;
    run_seq("restart", "111", "011", "111", "100", -500, 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
